// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked adder/subtractor with start/busy/done handshake
//
// Adds two WIDTH-bit operands CHUNK bits per clock, carrying between chunks
// through a register, so a wide add never has to close timing in one cycle.
//
// Parameters:
//   WIDTH  operand/result width; an integer multiple of CHUNK
//   CHUNK  bits added per clock (1..WIDTH)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, honoured only when not busy
//   sub    in   0: a+b+cin, 1: a-b (as a + ~b + 1, cin ignored)
//   a, b   in   operands, captured on the accepted start edge
//   cin    in   add-mode carry-in, captured on the accepted start edge
//   busy   out  high while chunks are processed (NCH cycles)
//   done   out  one-cycle pulse when s/cout/ovf have been updated
//   s      out  registered result, modulo 2^WIDTH
//   cout   out  carry out of the MSB (sub mode: 1 = no borrow)
//   ovf    out  two's-complement signed overflow

module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE_S = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;       // already inverted in sub mode
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  s_q;
    logic              cout_q;
    logic              ovf_q;
    logic              busy_q;
    logic              done_q;

    logic [BW-1:0]     base;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  acc_d;
    logic              last_chunk;
    logic              ovf_d;

    // Bit offset of the chunk being worked on this cycle.
    assign base       = BW'(32'(idx_q) * CHUNK);
    assign last_chunk = (idx_q == IDXW'(NCH - 1));

    always_comb begin
        chunk_sum = {1'b0, a_q[base +: CHUNK]}
                  + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
        acc_d = acc_q;
        acc_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Overflow only when both effective operands share a sign that the
    // result does not; acc_d already holds the final chunk on the last cycle.
    assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE_S: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= chunk_sum[CHUNK];
                    if (last_chunk) begin
                        s_q     <= acc_d;
                        cout_q  <= chunk_sum[CHUNK];
                        ovf_q   <= ovf_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE_S;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - self-checking bench for seq_chunk_adder at CHUNK=4, 1 and 16

module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic        op_sub = 1'b0;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic        op_cin = 1'b0;

    logic [2:0]  busy_v, done_v, cout_v, ovf_v;
    logic [15:0] s_v [3];

    logic [15:0] exp_s [3];
    logic        exp_c [3];
    logic        exp_o [3];

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(op_sub), .a(op_a), .b(op_b),
        .cin(op_cin), .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(op_sub), .a(op_a), .b(op_b),
        .cin(op_cin), .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(op_sub), .a(op_a), .b(op_b),
        .cin(op_cin), .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    function automatic int nch_of(input int d);
        case (d)
            0: return 4;
            1: return 16;
            default: return 1;
        endcase
    endfunction

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int ua, ub, sa, sb, r, full;
        logic [15:0] sr;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        if (!msub) begin
            full = ua + ub + (mcin ? 1 : 0);
            co   = (full >= 65536);
            sr   = 16'(full);
            r    = sa + sb + (mcin ? 1 : 0);
        end else begin
            co = (ua >= ub);
            sr = 16'(ua - ub);
            r  = sa - sb;
        end
        ov = (r > 32767) || (r < -32768);
        return {ov, co, sr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_expect();
        for (int d = 0; d < 3; d++) begin
            exp_s[d] = 16'h0;
            exp_c[d] = 1'b0;
            exp_o[d] = 1'b0;
        end
    endtask

    task automatic do_op(input int d, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tcin, input logic tsub, input string name);
        logic [17:0] m;
        int cnt;
        m = model(ta, tb, tcin, tsub);
        op_a = ta; op_b = tb; op_cin = tcin; op_sub = tsub;
        start_v[d] = 1'b1;
        tick();
        start_v[d] = 1'b0;
        op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom); op_sub = 1'($urandom);
        cnt = 0;
        while (busy_v[d] === 1'b1 && cnt < 100) begin
            tests++;
            if (s_v[d] !== exp_s[d] || cout_v[d] !== exp_c[d] || ovf_v[d] !== exp_o[d] || done_v[d] !== 1'b0) begin
                failed++;
                $display("FAIL %s hold: s=%h cout=%b ovf=%b done=%b, want s=%h cout=%b ovf=%b done=0",
                         name, s_v[d], cout_v[d], ovf_v[d], done_v[d], exp_s[d], exp_c[d], exp_o[d]);
            end
            cnt++;
            tick();
        end
        tests++;
        if (cnt !== nch_of(d)) begin
            failed++;
            $display("FAIL %s busy_cycles: got %0d, want %0d", name, cnt, nch_of(d));
        end
        tests++;
        if (done_v[d] !== 1'b1) begin
            failed++;
            $display("FAIL %s done: got %b, want 1", name, done_v[d]);
        end
        tests++;
        if ({ovf_v[d], cout_v[d], s_v[d]} !== m) begin
            failed++;
            $display("FAIL %s result: s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                     name, s_v[d], cout_v[d], ovf_v[d], m[15:0], m[16], m[17]);
        end
        exp_s[d] = m[15:0]; exp_c[d] = m[16]; exp_o[d] = m[17];
        tick();
        tests++;
        if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
            failed++;
            $display("FAIL %s after_done: done=%b busy=%b, want 0 0", name, done_v[d], busy_v[d]);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if ({busy_v[d], done_v[d], s_v[d], cout_v[d], ovf_v[d]} !== 20'h0) begin
                failed++;
                $display("FAIL %s dut%0d: busy=%b done=%b s=%h cout=%b ovf=%b, want all 0",
                         name, d, busy_v[d], done_v[d], s_v[d], cout_v[d], ovf_v[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        clear_expect();
    endtask

    task automatic test_directed();
        do_op(0, 16'h0000, 16'h0001, 1'b1, 1'b0, "add_small");
        do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
        do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        do_op(0, 16'h0000, 16'h8000, 1'b0, 1'b1, "sub_minint");
        do_op(1, 16'h0000, 16'h0001, 1'b1, 1'b0, "chunk1_add");
        do_op(2, 16'h0000, 16'h0001, 1'b1, 1'b0, "chunk16_add");
        do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, "chunk1_sub");
        do_op(2, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "chunk16_max");
    endtask

    task automatic test_start_while_busy();
        int pulses;
        logic [15:0] s_at_done;
        pulses = 0;
        s_at_done = 16'h0;
        op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; op_sub = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        op_a = 16'hFFFF; op_b = 16'hFFFF; op_cin = 1'b1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_v[0] === 1'b1) begin
                pulses++;
                s_at_done = s_v[0];
            end
            tick();
        end
        tests++;
        if (pulses !== 1) begin
            failed++;
            $display("FAIL busy_start pulses: got %0d, want 1", pulses);
        end
        tests++;
        if (s_at_done !== 16'h2345) begin
            failed++;
            $display("FAIL busy_start result: got %h, want 2345", s_at_done);
        end
        exp_s[0] = 16'h2345; exp_c[0] = 1'b0; exp_o[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pulses, busies;
        pulses = 0;
        busies = 0;
        op_a = 16'h00FF; op_b = 16'h0001; op_cin = 1'b0; op_sub = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        tick();
        rst_n = 1'b1;
        clear_expect();
        for (int i = 0; i < 8; i++) begin
            if (done_v[0] === 1'b1) pulses++;
            if (busy_v[0] === 1'b1) busies++;
            tick();
        end
        tests++;
        if (pulses !== 0 || busies !== 0 || s_v[0] !== 16'h0) begin
            failed++;
            $display("FAIL reset_mid after: done_pulses=%0d busy_cycles=%0d s=%h, want 0 0 0000",
                     pulses, busies, s_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, c1, c2;
        cyc = 0; c1 = -1; c2 = -1;
        op_a = 16'h0008; op_b = 16'h0008; op_cin = 1'b0; op_sub = 1'b0;
        start_v[0] = 1'b1;
        tick();
        op_a = 16'h000F; op_b = 16'h0001;
        while (c2 < 0 && cyc < 20) begin
            if (c1 >= 0) begin
                tests++;
                if (s_v[0] !== 16'h0010) begin
                    failed++;
                    $display("FAIL b2b glitch cycle %0d: s=%h, want 0010", cyc, s_v[0]);
                end
                if (cyc == c1 + 1) begin
                    tests++;
                    if (busy_v[0] !== 1'b1) begin
                        failed++;
                        $display("FAIL b2b restart: busy=%b, want 1", busy_v[0]);
                    end
                end
            end
            if (done_v[0] === 1'b1) begin
                if (c1 < 0) c1 = cyc;
                else begin
                    c2 = cyc;
                    start_v[0] = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        tests++;
        if (c1 < 0 || c2 < 0 || (c2 - c1) !== 5) begin
            failed++;
            $display("FAIL b2b spacing: first=%0d second=%0d, want 5 apart", c1, c2);
        end
        tests++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL b2b stop: done=%b busy=%b, want 0 0", done_v[0], busy_v[0]);
        end
        exp_s[0] = 16'h0010; exp_c[0] = 1'b0; exp_o[0] = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_op(i % 3, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor. It adds two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register. It sits beside the combinational ripple adders and is used where a wide add must not close timing in one cycle. It provides a start/busy/done handshake, carry-in, carry-out, a subtract mode and a signed-overflow flag.

Parameters:
WIDTH, 16, operand and sum width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits added per clock cycle; 1 <= CHUNK <= WIDTH.
NCH (local), WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
clk    input   1      system clock; all state updates on the rising edge
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only when not busy
sub    input   1      0 = a+b+cin; 1 = a-b (computed as a + ~b + 1; cin ignored)
a      input   WIDTH  operand A, sampled on the accepted start edge
b      input   WIDTH  operand B, sampled on the accepted start edge
cin    input   1      carry-in for add mode, sampled on the accepted start edge
busy   output  1      high while chunks are being processed
done   output  1      one-cycle pulse when the result is updated
s      output  WIDTH  registered sum/difference
cout   output  1      carry out of the MSB (sub mode: 1 = no borrow)
ovf    output  1      two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, s=0, cout=0, ovf=0. All internal operand, carry, index and accumulator registers are cleared.
- States:
  - IDLE: wait for start.
  - RUN: chunk index 0..NCH-1.
  - DONE: one cycle; done=1.
- IDLE or DONE with start=1 at edge T0:
  - Latch a.
  - Latch b, or ~b when sub=1.
  - Latch carry = cin (add) or 1 (sub).
  - idx=0; next state RUN; busy=1 from T0.
- RUN, each edge:
  - Add chunk idx of a and b plus the carry register.
  - Write the CHUNK-bit result into accumulator chunk idx; store the chunk carry-out in the carry register; idx++.
  - Chunk 0 is the LSBs.
- Last chunk (idx=NCH-1) at edge T0+NCH:
  - s <= accumulator including the final chunk.
  - cout <= final carry.
  - ovf <= (A[msb] == Beff[msb]) && (s[msb] != A[msb]), where Beff is the latched, possibly inverted, b.
  - Next state DONE; busy=0; done=1 for exactly one cycle.
- Latency: done is visible for the cycle after edge T0+NCH. busy is high for exactly NCH cycles.
- Outputs s, cout and ovf change only at the completion edge. They hold the previous result throughout RUN and after DONE until the next completion.
- start while busy=1: ignored, with no effect on the operation in flight. Operands are not re-sampled mid-operation.
- start during the DONE cycle: accepted as in IDLE. done pulses for that cycle, and busy rises at the same edge the state leaves DONE (back-to-back throughput: one result per NCH+1 cycles).
- start held high continuously: a new operation starts each time the state is in DONE.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only via cout and ovf.
- CHUNK == WIDTH: NCH=1; done follows start by 1 cycle plus the DONE cycle.
- Reset mid-operation: aborts immediately to the reset values above. No done pulse; the partial result is discarded.
- No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0x0000, b=0x0001, cin=1, sub=0, start pulse → busy high 4 cycles, then done=1 for 1 cycle; s=0x0002, cout=0, ovf=0.
2. a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Separately a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
3. sub=1, a=0x0005, b=0x0007, cin=1 → s=0xFFFE, cout=0, ovf=0. Separately sub=1, a=0x8000, b=0x0001 → s=0x7FFF, cout=1, ovf=1.
4. Start a=0x1234 + b=0x1111, then assert start with a=0xFFFF at RUN cycle 2 → the second start is ignored; s=0x2345, exactly one done pulse.
5. Assert rst_n=0 at RUN cycle 2 of a=0x00FF + b=0x0001 → busy, done, s, cout and ovf all read 0 asynchronously; no done pulse after release.
6. Hold start=1 across two operations (0x0008+0x0008, then 0x000F+0x0001) → done pulses 5 cycles apart; s=0x0010, then s=0x0010 with no glitch between. Repeat test 1 with CHUNK=1 (16 busy cycles) and with CHUNK=16 (1 busy cycle).
